// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  // Which requester the memory read data of the current cycle belongs to.
  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_IF   = 2'd1,
    R_D    = 2'd2
  } resp_st_e;

  // Instruction fetches are always full-word accesses.
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // Consecutive conflict cycles DATA may win before fetch is forced through.
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/unified_mem_arbiter_fairness_ctr.sv
// Saturating starvation counter: counts conflict cycles that DATA won and
// raises force_if once fetch has waited STARVE_MAX such cycles in a row.
module unified_mem_arbiter_fairness_ctr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             force_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Clear on a fetch grant, otherwise count DATA wins up to the bound.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_if = (cnt == CNT_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. One grant per cycle; read data returns one cycle later and is
// steered back to the requester recorded in resp_st.
//
// Handshake: a requester holds req (and its address/data) until it sees gnt
// high in the same cycle; the access is accepted on that clock edge. A read
// response is flagged by rvalid for exactly one cycle, the cycle after the
// grant, and has no back-pressure. Stores produce no response.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  resp_st_e         resp_st;
  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;
  logic             conflict;

  assign conflict = if_req && d_req;

  // DATA wins conflicts until fetch has been starved STARVE_MAX times.
  // Grants are held low while reset is asserted.
  assign if_gnt = rst && if_req && (!d_req || force_if);
  assign d_gnt  = rst && d_req && !(if_req && force_if);
  assign stall  = if_req && !if_gnt;

  unified_mem_arbiter_fairness_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_fair (
    .clk      (clk),
    .rst      (rst),
    .inc      (conflict && d_gnt),
    .clr      (if_gnt),
    .cnt      (starve_cnt),
    .force_if (force_if)
  );

  // Drive the memory port from whichever request was granted; idle is all zero.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (if_gnt) begin
      mem_en     = 1'b1;
      mem_funct3 = FUNCT3_WORD;
      mem_addr   = if_addr;
    end else if (d_gnt) begin
      mem_en     = 1'b1;
      mem_we     = d_we;
      mem_funct3 = d_funct3;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end
  end

  // Remember who owns next cycle's read data; stores and idle cycles own none.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_st <= R_NONE;
    end else if (if_gnt) begin
      resp_st <= R_IF;
    end else if (d_gnt && !d_we) begin
      resp_st <= R_D;
    end else begin
      resp_st <= R_NONE;
    end
  end

  // Responses are suppressed during reset so an in-flight read is dropped.
  assign if_rvalid = rst && (resp_st == R_IF);
  assign d_rvalid  = rst && (resp_st == R_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a one-cycle-latency memory model.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  int n_tests;
  int n_fail;

  // Word-wide model memory indexed by byte address (no alignment handling).
  logic [31:0] mem [256];

  unified_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_funct3   (d_funct3),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall      (stall)
  );

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle: inputs change just after the rising edge, checks at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_check_point();
    @(negedge clk);
  endtask

  task automatic set_load(input logic req, input logic [7:0] addr);
    d_req    = req;
    d_we     = 1'b0;
    d_funct3 = 3'b010;
    d_addr   = addr;
    d_wdata  = '0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'h00500093;
    mem[8'h08] = 32'h12345678;
    mem[8'h10] = 32'hCAFEF00D;
    mem[8'h30] = 32'hA5A5_0030;
    mem_rdata = '0;

    // Reset with both requests high
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 8'h04;
    set_load(1'b1, 8'h10);
    next_cycle();
    next_cycle();
    to_check_point();
    check("rst_if_gnt", {63'b0, if_gnt}, 64'd0);
    check("rst_d_gnt", {63'b0, d_gnt}, 64'd0);
    check("rst_mem_en", {63'b0, mem_en}, 64'd0);
    check("rst_if_rvalid", {63'b0, if_rvalid}, 64'd0);
    check("rst_d_rvalid", {63'b0, d_rvalid}, 64'd0);
    check("rst_resp_st", {62'b0, dut.resp_st}, 64'd0);
    check("rst_starve", {61'b0, dut.starve_cnt}, 64'd0);

    // Release: DATA wins the first conflict (load from 0x10)
    next_cycle();
    rst = 1'b1;
    to_check_point();
    check("rel_d_gnt", {63'b0, d_gnt}, 64'd1);
    check("rel_if_gnt", {63'b0, if_gnt}, 64'd0);
    check("rel_stall", {63'b0, stall}, 64'd1);
    check("rel_mem_addr", {56'b0, mem_addr}, 64'h10);

    // Fetch granted while the load returns in the same cycle
    next_cycle();
    set_load(1'b0, 8'h00);
    to_check_point();
    check("b2b_if_gnt", {63'b0, if_gnt}, 64'd1);
    check("b2b_d_rvalid", {63'b0, d_rvalid}, 64'd1);
    check("b2b_d_rdata", {32'b0, d_rdata}, 64'hCAFEF00D);
    check("b2b_if_rdata0", {32'b0, if_rdata}, 64'd0);
    check("b2b_stall", {63'b0, stall}, 64'd0);
    check("b2b_starve_clr_pre", {61'b0, dut.starve_cnt}, 64'd1);
    check("b2b_mem_addr", {56'b0, mem_addr}, 64'h04);
    check("b2b_mem_we", {63'b0, mem_we}, 64'd0);
    check("b2b_mem_f3", {61'b0, mem_funct3}, 64'h2);

    // IF-only: fetch response arrives, next fetch granted
    next_cycle();
    to_check_point();
    check("if_rvalid", {63'b0, if_rvalid}, 64'd1);
    check("if_rdata", {32'b0, if_rdata}, 64'h00500093);
    check("if_d_rvalid", {63'b0, d_rvalid}, 64'd0);
    check("if_d_rdata0", {32'b0, d_rdata}, 64'd0);
    check("if_gnt_again", {63'b0, if_gnt}, 64'd1);
    check("if_starve_clr", {61'b0, dut.starve_cnt}, 64'd0);

    // Store 0xDEADBEEF to 0x20
    next_cycle();
    if_req   = 1'b0;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_funct3 = 3'b010;
    d_addr   = 8'h20;
    d_wdata  = 32'hDEADBEEF;
    to_check_point();
    check("st_d_gnt", {63'b0, d_gnt}, 64'd1);
    check("st_mem_en", {63'b0, mem_en}, 64'd1);
    check("st_mem_we", {63'b0, mem_we}, 64'd1);
    check("st_mem_addr", {56'b0, mem_addr}, 64'h20);
    check("st_mem_wdata", {32'b0, mem_wdata}, 64'hDEADBEEF);
    check("st_mem_f3", {61'b0, mem_funct3}, 64'h2);
    check("st_stall", {63'b0, stall}, 64'd0);

    // Idle cycle after the store: no response, memory port quiet
    next_cycle();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_wdata = '0;
    to_check_point();
    check("st_no_rvalid", {63'b0, d_rvalid}, 64'd0);
    check("idle_mem_en", {63'b0, mem_en}, 64'd0);
    check("idle_mem_addr", {56'b0, mem_addr}, 64'h00);
    check("idle_resp_st", {62'b0, dut.resp_st}, 64'd0);

    // Load back from 0x20
    next_cycle();
    set_load(1'b1, 8'h20);
    to_check_point();
    check("ld20_d_gnt", {63'b0, d_gnt}, 64'd1);
    next_cycle();
    set_load(1'b0, 8'h00);
    to_check_point();
    check("ld20_rvalid", {63'b0, d_rvalid}, 64'd1);
    check("ld20_rdata", {32'b0, d_rdata}, 64'hDEADBEEF);

    // Starvation bound: continuous conflict gives D,D,D,D,IF repeating
    next_cycle();
    if_req  = 1'b1;
    if_addr = 8'h08;
    set_load(1'b1, 8'h30);
    for (int k = 0; k < 10; k++) begin
      to_check_point();
      check($sformatf("sv_cnt_%0d", k), {61'b0, dut.starve_cnt}, 64'(k % 5));
      check($sformatf("sv_if_gnt_%0d", k), {63'b0, if_gnt}, 64'((k % 5) == 4));
      check($sformatf("sv_d_gnt_%0d", k), {63'b0, d_gnt}, 64'((k % 5) != 4));
      check($sformatf("sv_stall_%0d", k), {63'b0, stall}, 64'((k % 5) != 4));
      if (k > 0) begin
        check($sformatf("sv_d_rvalid_%0d", k), {63'b0, d_rvalid}, 64'(((k - 1) % 5) != 4));
        check($sformatf("sv_d_rdata_%0d", k), {32'b0, d_rdata},
              (((k - 1) % 5) != 4) ? 64'hA5A50030 : 64'd0);
        check($sformatf("sv_if_rdata_%0d", k), {32'b0, if_rdata},
              (((k - 1) % 5) == 4) ? 64'h12345678 : 64'd0);
      end
      next_cycle();
    end

    // Reset mid-read: grant a load, then reset before its response is used
    if_req = 1'b0;
    set_load(1'b1, 8'h10);
    to_check_point();
    check("mr_d_gnt", {63'b0, d_gnt}, 64'd1);
    next_cycle();
    rst = 1'b0;
    set_load(1'b0, 8'h00);
    to_check_point();
    check("mr_rvalid_in_rst", {63'b0, d_rvalid}, 64'd0);
    check("mr_rdata_in_rst", {32'b0, d_rdata}, 64'd0);
    next_cycle();
    to_check_point();
    check("mr_resp_st", {62'b0, dut.resp_st}, 64'd0);
    check("mr_starve", {61'b0, dut.starve_cnt}, 64'd0);
    next_cycle();
    rst = 1'b1;
    to_check_point();
    check("mr_rvalid_after", {63'b0, d_rvalid}, 64'd0);
    check("mr_mem_en_after", {63'b0, mem_en}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, 256-byte unified memory between instruction fetch (IF) and load/store (DATA).
- Sits between the PC/fetch logic and the load/store path of the processor, replacing the separate instruction and data memories.
- Grants one access per cycle and routes the one-cycle-latency read data back to the correct requester.
- Generates the fetch stall, and a bounded-starvation counter keeps fetch from being locked out by back-to-back loads and stores.

Parameters:
- ADDR_W, 8, byte address width; the memory has 2^ADDR_W bytes.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive conflict cycles DATA may win before IF is forced to win.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge)
- if_req  in  1  fetch request, held until granted
- if_addr  in  ADDR_W  fetch byte address (PC)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid (the cycle after if_gnt)
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  access size/sign, passed to memory unchanged
- d_addr  in  ADDR_W  data byte address (ALU_out[ADDR_W-1:0])
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  d_rdata valid (the cycle after a load grant)
- d_rdata  out  DATA_W  load result
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_funct3  out  3  to memory
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en
- stall  out  1  if_req && !if_gnt; freezes the PC

Behaviour:
- Arbitration is combinational within the cycle; at most one of if_gnt and d_gnt is 1.
  - Only one request active: that requester is granted.
  - Both active: DATA wins unless starve_cnt == STARVE_MAX, in which case IF wins.
- mem_* outputs mirror the granted request.
  - IF grant: mem_we=0, mem_funct3=3'b010.
  - No grant: mem_en=0, other mem_* outputs 0.
- Response FSM, state register resp_st:
  - States: R_NONE, R_IF, R_D.
  - Next state: R_IF after an IF grant; R_D after a load grant; R_NONE after a store grant or no grant.
- Responses:
  - In R_IF: if_rvalid=1 and if_rdata=mem_rdata.
  - In R_D: d_rvalid=1 and d_rdata=mem_rdata.
  - rdata outputs are 0 when the matching rvalid is 0.
- A new grant may be issued in the same cycle as the previous response (back-to-back, full throughput).
- Stores complete in the grant cycle; no rvalid is generated.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments when both request and DATA wins.
  - Clears when IF is granted.
  - Holds otherwise.
  - Never exceeds STARVE_MAX.
- Addresses pass through unmodified; wrap-around above 2^ADDR_W-1 is the caller's (mod 256). No alignment checking.
- Reset (rst=0 at a clock edge):
  - resp_st=R_NONE, starve_cnt=0.
  - All outputs 0: if_rvalid, d_rvalid, and rdata outputs; gnt and mem_en are also forced 0 while rst=0.
  - A read outstanding at reset is dropped; no rvalid follows reset release.
- A request deasserted without a grant is simply dropped; no state change.

Decomposition:
- Shared package:
  - resp_st encoding (R_NONE=2'd0, R_IF=2'd1, R_D=2'd2).
  - FUNCT3_WORD=3'b010.
  - Default STARVE_MAX.
- Sub-module fairness_ctr: the saturating starve counter plus the force_if output (cnt == STARVE_MAX).
- Arbiter mux and response FSM stay in the top module.

Test Plan:
- Reset: hold rst=0 with both requests high → all gnt/rvalid/mem_en 0. Release rst → cycle 1 d_gnt=1, if_gnt=0, stall=1.
- IF-only: if_req=1, if_addr=8'h04, memory word 32'h00500093 → if_gnt=1, mem_addr=8'h04, mem_we=0. Next cycle if_rvalid=1, if_rdata=32'h00500093, d_rvalid=0.
- Load-then-fetch back-to-back:
  - Cycle 0: d_req load at 8'h10, if_req held → d_gnt=1, stall=1.
  - Cycle 1: if_gnt=1; d_rvalid=1 with mem[8'h10] in the same cycle.
  - Cycle 2: if_rvalid=1.
- Store: d_we=1, d_addr=8'h20, d_wdata=32'hDEADBEEF, d_funct3=3'b010 → mem_en=1, mem_we=1, matching mem_* outputs. Next cycle d_rvalid=0. A later load from 8'h20 returns 32'hDEADBEEF.
- Starvation bound, STARVE_MAX=4: both requests high continuously → grant pattern D,D,D,D,IF repeating; starve_cnt reaches 4 and then clears.
- Reset mid-read: grant a load, assert rst=0 on the next edge → d_rvalid stays 0 and resp_st=R_NONE after the edge.
